mole_scheduler: RTL and testbench

Game-level sequencer for the whack-a-mole display. It picks which of the 5 holes shows a mole and steps the mole through rise / hold / retreat. Its oval_select and anim_phase outputs drive the sprite renderer's position select and animation state directly. It also judges whack attempts, keeps score and misses, and ends the game after too many misses.

---
 rtl/mole_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_mole_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_scheduler.sv
// Whack-a-mole sequencer: picks a hole, animates rise/hold/retreat, judges whacks, keeps score and misses.
// Optional MOLE_SPEEDUP_EN: hold time shrinks by UP_STEP per scored hit, floored at UP_MIN.
module mole_scheduler #(
  parameter int unsigned RISE_TICKS = 2,
  parameter int unsigned UP_TICKS   = 30,
  parameter int unsigned GAP_TICKS  = 20,
  parameter int unsigned MAX_MISSES = 5,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
`ifdef MOLE_SPEEDUP_EN
  ,
  parameter int unsigned UP_MIN     = 8,
  parameter int unsigned UP_STEP    = 2
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       whack_valid,
  input  logic [2:0] whack_oval,
  output logic [2:0] oval_select,
  output logic [1:0] anim_phase,
  output logic       mole_visible,
  output logic       hit_pulse,
  output logic [7:0] score,
  output logic [3:0] misses,
  output logic       game_over
);

  localparam int unsigned MAX_A = (RISE_TICKS > UP_TICKS) ? RISE_TICKS : UP_TICKS;
  localparam int unsigned MAX_B = (GAP_TICKS > MAX_A) ? GAP_TICKS : MAX_A;
`ifdef MOLE_SPEEDUP_EN
  localparam int unsigned MAX_T = (UP_MIN > MAX_B) ? UP_MIN : MAX_B;
`else
  localparam int unsigned MAX_T = MAX_B;
`endif
  localparam int CNT_W = $clog2(MAX_T + 1);

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_RISE, S_UP, S_FALL} state_t;

  state_t             r_state, w_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [1:0]         r_phase, w_phase;
  logic [2:0]         r_oval, w_oval;
  logic [2:0]         r_prev, w_prev;
  logic [7:0]         r_score, w_score;
  logic [3:0]         r_misses, w_misses;
  logic               r_game_over, w_game_over;
  logic               r_hit, w_hit;
  logic               r_visible, w_visible;
  logic [7:0]         r_lfsr, w_lfsr;

  logic [7:0]         w_lfsr_adv;
  logic [2:0]         w_cand;
  logic [2:0]         w_hole;
  logic               w_hit_ok;
  logic [3:0]         w_miss_inc;
  logic [7:0]         w_score_inc;
  logic [CNT_W-1:0]   w_up_load;

`ifdef MOLE_SPEEDUP_EN
  logic [CNT_W-1:0]   r_up_len, w_up_len, w_up_dec;
  assign w_up_dec  = (32'(r_up_len) >= UP_MIN + UP_STEP) ? (r_up_len - CNT_W'(UP_STEP))
                                                         : CNT_W'(UP_MIN);
  assign w_up_load = r_up_len;
`else
  assign w_up_load = CNT_W'(UP_TICKS);
`endif

  // Galois right-shift form of x^8+x^6+x^5+x^4+1
  assign w_lfsr_adv  = r_lfsr[0] ? ({1'b0, r_lfsr[7:1]} ^ 8'hB8) : {1'b0, r_lfsr[7:1]};
  assign w_cand      = (r_lfsr[2:0] >= 3'd5) ? (r_lfsr[2:0] - 3'd5) : r_lfsr[2:0];
  assign w_hole      = (w_cand != r_prev) ? w_cand : ((w_cand == 3'd4) ? 3'd0 : w_cand + 3'd1);
  assign w_hit_ok    = whack_valid && (whack_oval == r_oval) &&
                       ((r_state == S_UP) ||
                        (((r_state == S_RISE) || (r_state == S_FALL)) && r_phase[1]));
  assign w_miss_inc  = r_misses + 4'd1;
  assign w_score_inc = (r_score == 8'hFF) ? r_score : r_score + 8'd1;

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_phase     = r_phase;
    w_oval      = r_oval;
    w_prev      = r_prev;
    w_score     = r_score;
    w_misses    = r_misses;
    w_game_over = r_game_over;
    w_hit       = 1'b0;
    w_lfsr      = (r_state == S_IDLE) ? r_lfsr : w_lfsr_adv;
`ifdef MOLE_SPEEDUP_EN
    w_up_len    = r_up_len;
`endif
    if (stop) begin
      w_state = S_IDLE;
      w_oval  = 3'd7;
      w_phase = 2'd0;
    end else if (w_hit_ok) begin
      w_hit   = 1'b1;
      w_score = w_score_inc;
      w_state = S_GAP;
      w_cnt   = CNT_W'(GAP_TICKS);
      w_oval  = 3'd7;
      w_phase = 2'd0;
`ifdef MOLE_SPEEDUP_EN
      w_up_len = w_up_dec;
`endif
    end else if (r_state == S_IDLE) begin
      if (start) begin
        w_state     = S_GAP;
        w_cnt       = CNT_W'(GAP_TICKS);
        w_score     = 8'd0;
        w_misses    = 4'd0;
        w_game_over = 1'b0;
`ifdef MOLE_SPEEDUP_EN
        w_up_len    = CNT_W'(UP_TICKS);
`endif
      end
    end else if (tick) begin
      if (r_cnt != CNT_W'(1)) begin
        w_cnt = r_cnt - CNT_W'(1);
      end else begin
        case (r_state)
          S_GAP: begin
            w_state = S_RISE;
            w_oval  = w_hole;
            w_prev  = w_hole;
            w_phase = 2'd0;
            w_cnt   = CNT_W'(RISE_TICKS);
          end
          S_RISE: begin
            if (r_phase != 2'd3) begin
              w_phase = r_phase + 2'd1;
              w_cnt   = CNT_W'(RISE_TICKS);
            end else begin
              w_state = S_UP;
              w_cnt   = w_up_load;
            end
          end
          S_UP: begin
            w_state = S_FALL;
            w_cnt   = CNT_W'(RISE_TICKS);
          end
          S_FALL: begin
            if (r_phase != 2'd0) begin
              w_phase = r_phase - 2'd1;
              w_cnt   = CNT_W'(RISE_TICKS);
            end else begin
              w_misses = w_miss_inc;
              w_oval   = 3'd7;
              if (w_miss_inc == 4'(MAX_MISSES)) begin
                w_state     = S_IDLE;
                w_game_over = 1'b1;
              end else begin
                w_state = S_GAP;
                w_cnt   = CNT_W'(GAP_TICKS);
              end
            end
          end
          default: w_state = S_IDLE;
        endcase
      end
    end
    w_visible = (w_state == S_RISE) || (w_state == S_UP) || (w_state == S_FALL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_phase     <= 2'd0;
      r_oval      <= 3'd7;
      r_prev      <= 3'd7;
      r_score     <= 8'd0;
      r_misses    <= 4'd0;
      r_game_over <= 1'b0;
      r_hit       <= 1'b0;
      r_visible   <= 1'b0;
      r_lfsr      <= LFSR_SEED;
`ifdef MOLE_SPEEDUP_EN
      r_up_len    <= CNT_W'(UP_TICKS);
`endif
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_phase     <= w_phase;
      r_oval      <= w_oval;
      r_prev      <= w_prev;
      r_score     <= w_score;
      r_misses    <= w_misses;
      r_game_over <= w_game_over;
      r_hit       <= w_hit;
      r_visible   <= w_visible;
      r_lfsr      <= w_lfsr;
`ifdef MOLE_SPEEDUP_EN
      r_up_len    <= w_up_len;
`endif
    end
  end

  assign oval_select  = r_oval;
  assign anim_phase   = r_phase;
  assign mole_visible = r_visible;
  assign hit_pulse    = r_hit;
  assign score        = r_score;
  assign misses       = r_misses;
  assign game_over    = r_game_over;

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: directed scenarios plus random play against a behavioural game model.
module tb_mole_scheduler;

  localparam int RT = 1;
  localparam int GT = 2;
  localparam int MM = 2;
`ifdef MOLE_SPEEDUP_EN
  localparam int UT    = 10;
  localparam int UMIN  = 8;
  localparam int USTEP = 2;
`else
  localparam int UT    = 4;
`endif
  localparam int MI = 0, MG = 1, MR = 2, MU = 3, MF = 4;

  logic       clk = 1'b0;
  logic       rst, tick, start, stop, whack_valid;
  logic [2:0] whack_oval;
  logic [2:0] oval_select;
  logic [1:0] anim_phase;
  logic       mole_visible, hit_pulse, game_over;
  logic [7:0] score;
  logic [3:0] misses;

  mole_scheduler #(
    .RISE_TICKS(RT), .UP_TICKS(UT), .GAP_TICKS(GT), .MAX_MISSES(MM), .LFSR_SEED(8'hA5)
`ifdef MOLE_SPEEDUP_EN
    , .UP_MIN(UMIN), .UP_STEP(USTEP)
`endif
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .whack_valid(whack_valid), .whack_oval(whack_oval),
    .oval_select(oval_select), .anim_phase(anim_phase), .mole_visible(mole_visible),
    .hit_pulse(hit_pulse), .score(score), .misses(misses), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // game model
  int m_mode, m_left, m_phase, m_oval, m_prev, m_score, m_miss, m_lfsr;
  bit m_go, m_hit;
`ifdef MOLE_SPEEDUP_EN
  int m_uplen;
`endif
  int tb_last_oval, tb_prev_hole;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = MI; m_left = 0; m_phase = 0; m_oval = 7; m_prev = 7;
    m_score = 0; m_miss = 0; m_go = 0; m_hit = 0; m_lfsr = 'hA5;
`ifdef MOLE_SPEEDUP_EN
    m_uplen = UT;
`endif
    tb_last_oval = 7; tb_prev_hole = 7;
  endtask

  function automatic int pick_hole();
    int c;
    c = m_lfsr % 8;
    if (c >= 5) c = c - 5;
    if (c == m_prev) c = (c + 1) % 5;
    return c;
  endfunction

  function automatic int hold_len();
`ifdef MOLE_SPEEDUP_EN
    return m_uplen;
`else
    return UT;
`endif
  endfunction

  function automatic bit hittable();
    return (m_mode == MU) || ((m_mode == MR || m_mode == MF) && m_phase >= 2);
  endfunction

  // one clock of game rules, applied to the inputs about to be sampled
  task automatic model_step();
    int nl;
    bit can_hit;
    nl = (m_mode == MI) ? m_lfsr : ((m_lfsr & 1) ? ((m_lfsr >> 1) ^ 'hB8) : (m_lfsr >> 1));
    can_hit = whack_valid && (int'(whack_oval) == m_oval) && hittable();
    m_hit = 0;
    if (stop) begin
      m_mode = MI; m_oval = 7; m_phase = 0;
    end else if (can_hit) begin
      m_hit = 1;
      m_score = (m_score < 255) ? m_score + 1 : 255;
      m_mode = MG; m_left = GT; m_oval = 7; m_phase = 0;
`ifdef MOLE_SPEEDUP_EN
      m_uplen = (m_uplen - USTEP > UMIN) ? m_uplen - USTEP : UMIN;
`endif
    end else if (m_mode == MI) begin
      if (start) begin
        m_mode = MG; m_left = GT; m_score = 0; m_miss = 0; m_go = 0;
`ifdef MOLE_SPEEDUP_EN
        m_uplen = UT;
`endif
      end
    end else if (tick) begin
      if (m_left > 1) m_left--;
      else begin
        case (m_mode)
          MG: begin m_oval = pick_hole(); m_prev = m_oval; m_mode = MR; m_phase = 0; m_left = RT; end
          MR: if (m_phase < 3) begin m_phase++; m_left = RT; end
              else begin m_mode = MU; m_left = hold_len(); end
          MU: begin m_mode = MF; m_left = RT; end
          default: if (m_phase > 0) begin m_phase--; m_left = RT; end
              else begin
                m_miss++; m_oval = 7;
                if (m_miss == MM) begin m_mode = MI; m_go = 1; end
                else begin m_mode = MG; m_left = GT; end
              end
        endcase
      end
    end
    m_lfsr = nl;
  endtask

  task automatic check_outputs();
    chk("oval_select", oval_select, m_oval);
    chk("anim_phase", anim_phase, m_phase);
    chk("mole_visible", mole_visible, (m_mode == MR || m_mode == MU || m_mode == MF) ? 1 : 0);
    chk("hit_pulse", hit_pulse, m_hit);
    chk("score", score, m_score);
    chk("misses", misses, m_miss);
    chk("game_over", game_over, m_go);
    if (oval_select != 3'd7 && tb_last_oval == 7) begin
      if (tb_prev_hole != 7) chk("hole_repeat", (int'(oval_select) != tb_prev_hole) ? 1 : 0, 1);
      tb_prev_hole = oval_select;
    end
    tb_last_oval = oval_select;
  endtask

  task automatic cyc(input bit t, input bit s, input bit p, input bit wv, input int wo);
    tick = t; start = s; stop = p; whack_valid = wv; whack_oval = 3'(wo);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  int hits, held, k;
  bit done;

  initial begin
    rst = 1'b1; tick = 0; start = 0; stop = 0; whack_valid = 0; whack_oval = 0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // miss cycle, then the next appearance
    cyc(1, 1, 0, 0, 0);
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      cyc(1, 0, 0, 0, 0);
      done = (m_miss == 1 && m_mode == MR);
    end
    chk("miss_cycle_reached", done, 1);

    // scored hit while fully up
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (m_mode == MU) begin cyc(1, 0, 0, 1, m_oval); done = 1; end
      else cyc(1, 0, 0, 0, 0);
    end
    chk("hit_reached", done, 1);
    chk("hit_score", score, 1);
    chk("hit_oval_hidden", oval_select, 7);
    chk("hit_misses", misses, 1);

    // ignored whacks until the second miss ends the game
    done = 0;
    for (int i = 0; i < 150 && !done; i++) begin
      if (m_mode == MG)                     cyc(1, 0, 0, 1, (m_prev == 7) ? 0 : m_prev);
      else if (m_mode == MR && m_phase < 2) cyc(1, 0, 0, 1, m_oval);
      else if (m_mode == MU)                cyc(1, 0, 0, 1, (m_oval + 1) % 5);
      else                                  cyc(1, 0, 0, 0, 0);
      done = m_go;
    end
    chk("ignored_score", score, 1);
    chk("go_flag", game_over, 1);
    chk("go_misses", misses, MM);
    chk("go_hidden", mole_visible, 0);
    cyc(1, 1, 0, 0, 0);
    chk("restart_score", score, 0);
    chk("restart_misses", misses, 0);
    chk("restart_go", game_over, 0);

    // one hit, then abort during the rise of the next mole
    done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      if (m_score == 0 && hittable()) cyc(1, 0, 0, 1, m_oval);
      else if (m_score == 1 && m_mode == MR) begin cyc(1, 0, 1, 0, 0); done = 1; end
      else cyc(1, 0, 0, 0, 0);
    end
    chk("stop_reached", done, 1);
    chk("stop_oval", oval_select, 7);
    chk("stop_score", score, 1);

    // random play
    for (int i = 0; i < 6000; i++) begin
      k = $urandom % 2;
      cyc(($urandom % 3) != 0, ($urandom % 40) == 0, ($urandom % 300) == 0, ($urandom % 4) == 0,
          (k == 1 && m_oval != 7) ? m_oval : int'($urandom % 5));
    end

    // score saturation
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    hits = 0;
    for (int i = 0; i < 6000 && hits < 260; i++) begin
      if (hittable()) cyc(1, 0, 0, 1, m_oval);
      else cyc(1, 0, 0, 0, 0);
      if (m_hit) hits++;
    end
    chk("sat_hits", hits, 260);
    chk("sat_score", score, 255);
    held = score;

    // asynchronous reset mid-game
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      cyc(1, 0, 0, 0, 0);
      done = (m_mode == MU);
    end
    tick = 0; start = 0; stop = 0; whack_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst_oval", oval_select, 7);
    chk("arst_score", score, 0);
    chk("arst_visible", mole_visible, 0);
    chk("arst_phase", anim_phase, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 30; i++) cyc(1, 0, 0, 0, 0);
    chk("pre_reset_score_seen", held, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
